// File: rtl/uart_rib_bridge.sv
// uart_rib_bridge: serial debug command parser driving RIB master read/write transactions
module usart_core #(
  parameter logic [15:0] CLK_DIV = 16'd868
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_rx,
  output logic       o_tx,
  input  logic       i_tx_en,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_rdy,
  output logic       o_rx_vld,
  output logic       o_rx_err,
  output logic [7:0] o_rx_data
);
  logic [1:0] rx_sync;
  logic rx_s, rbusy, tbusy;
  logic [15:0] rtmr, ttmr;
  logic [3:0] rbit, tcnt;
  logic [7:0] rsh;
  logic [9:0] tsh;
  assign rx_s = rx_sync[1];
  assign o_tx = tsh[0];
  assign o_tx_rdy = ~tbusy;
  // receiver: confirm start mid-bit, sample 8 data bits LSB first, then judge the stop bit
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rx_sync <= 2'b11;
      rbusy <= 1'b0;
      rtmr <= '0;
      rbit <= '0;
      rsh <= '0;
      o_rx_vld <= 1'b0;
      o_rx_err <= 1'b0;
      o_rx_data <= '0;
    end else begin
      rx_sync <= {rx_sync[0], i_rx};
      o_rx_vld <= 1'b0;
      o_rx_err <= 1'b0;
      if (!rbusy) begin
        if (!rx_s) begin
          rbusy <= 1'b1;
          rtmr <= CLK_DIV >> 1;
          rbit <= '0;
        end
      end else if (rbit == 4'd10) begin
        if (rx_s) rbusy <= 1'b0;
      end else if (rtmr != 16'd0) begin
        rtmr <= rtmr - 16'd1;
      end else begin
        rtmr <= CLK_DIV - 16'd1;
        if (rbit == 4'd0) begin
          if (rx_s) rbusy <= 1'b0;
          else rbit <= 4'd1;
        end else if (rbit < 4'd9) begin
          rsh <= {rx_s, rsh[7:1]};
          rbit <= rbit + 4'd1;
        end else begin
          o_rx_vld <= rx_s;
          o_rx_err <= ~rx_s;
          o_rx_data <= rsh;
          if (rx_s) rbusy <= 1'b0;
          else rbit <= 4'd10;
        end
      end
    end
  end
  // transmitter: shift out start, 8 data bits and stop, line idles high
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tbusy <= 1'b0;
      ttmr <= '0;
      tcnt <= '0;
      tsh <= '1;
    end else if (!tbusy) begin
      if (i_tx_en) begin
        tsh <= {1'b1, i_tx_data, 1'b0};
        tbusy <= 1'b1;
        ttmr <= CLK_DIV - 16'd1;
        tcnt <= '0;
      end
    end else if (ttmr != 16'd0) begin
      ttmr <= ttmr - 16'd1;
    end else begin
      ttmr <= CLK_DIV - 16'd1;
      tsh <= {1'b1, tsh[9:1]};
      if (tcnt == 4'd9) tbusy <= 1'b0;
      else tcnt <= tcnt + 4'd1;
    end
  end
endmodule

module uart_rib_bridge #(
  parameter logic [23:0] BYTE_TIMEOUT = 24'd1_000_000,
  parameter logic [15:0] BUS_TIMEOUT = 16'd256,
  parameter logic [15:0] CLK_DIV = 16'd868
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_rx,
  output logic        o_tx,
  output logic [31:0] o_ribm_addr,
  output logic        o_ribm_wrcs,
  output logic [3:0]  o_ribm_mask,
  output logic [31:0] o_ribm_wdata,
  input  logic [31:0] i_ribm_rdata,
  output logic        o_ribm_req,
  input  logic        i_ribm_gnt,
  input  logic        i_ribm_rsp,
  output logic        o_ribm_rdy,
  output logic        o_busy
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_REQ, BUS_RSP, TX_LOAD, TX_WAIT} state_t;
  state_t state;
  logic rx_vld, rx_err, rx_vld_q, rx_err_q, vld_edge, err_edge;
  logic tx_en, tx_rdy;
  logic [7:0] rx_data, tx_byte;
  logic [1:0] cnt;
  logic [2:0] tx_num;
  logic [31:0] txq;
  logic [23:0] byte_tmr;
  logic [15:0] bus_tmr;
  assign err_edge = rx_err & ~rx_err_q;
  assign vld_edge = rx_vld & ~rx_vld_q & ~err_edge;
  assign o_busy = state != IDLE;
  usart_core #(.CLK_DIV(CLK_DIV)) u_usart (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_rx(i_rx),
    .o_tx(o_tx),
    .i_tx_en(tx_en),
    .i_tx_data(tx_byte),
    .o_tx_rdy(tx_rdy),
    .o_rx_vld(rx_vld),
    .o_rx_err(rx_err),
    .o_rx_data(rx_data)
  );
  // command FSM: parse frame, run one bus transaction, stream the reply
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      rx_vld_q <= 1'b0;
      rx_err_q <= 1'b0;
      o_ribm_addr <= '0;
      o_ribm_wrcs <= 1'b0;
      o_ribm_mask <= '0;
      o_ribm_wdata <= '0;
      o_ribm_req <= 1'b0;
      o_ribm_rdy <= 1'b0;
      tx_en <= 1'b0;
      tx_byte <= '0;
      cnt <= '0;
      tx_num <= '0;
      txq <= '0;
      byte_tmr <= '0;
      bus_tmr <= '0;
    end else begin
      rx_vld_q <= rx_vld;
      rx_err_q <= rx_err;
      case (state)
        IDLE: begin
          if (vld_edge && (rx_data == 8'h57 || rx_data == 8'h52)) begin
            o_ribm_wrcs <= rx_data == 8'h57;
            cnt <= '0;
            byte_tmr <= '0;
            state <= ADDR;
          end
        end
        ADDR, WDATA: begin
          if (err_edge) begin
            txq <= 32'h45;
            tx_num <= 3'd1;
            state <= TX_LOAD;
          end else if (vld_edge) begin
            byte_tmr <= '0;
            cnt <= cnt + 2'd1;
            if (state == ADDR) o_ribm_addr <= {rx_data, o_ribm_addr[31:8]};
            else o_ribm_wdata <= {rx_data, o_ribm_wdata[31:8]};
            if (cnt == 2'd3) begin
              if (state == ADDR && o_ribm_wrcs) begin
                state <= WDATA;
              end else begin
                state <= BUS_REQ;
                o_ribm_req <= 1'b1;
                o_ribm_mask <= 4'hF;
                bus_tmr <= '0;
              end
            end
          end else if (byte_tmr >= BYTE_TIMEOUT - 24'd1) begin
            state <= IDLE;
          end else begin
            byte_tmr <= byte_tmr + 24'd1;
          end
        end
        BUS_REQ: begin
          if (i_ribm_gnt) begin
            o_ribm_req <= 1'b0;
            bus_tmr <= '0;
            if (i_ribm_rsp) begin
              txq <= o_ribm_wrcs ? 32'h4B : i_ribm_rdata;
              tx_num <= o_ribm_wrcs ? 3'd1 : 3'd4;
              state <= TX_LOAD;
            end else begin
              o_ribm_rdy <= 1'b1;
              state <= BUS_RSP;
            end
          end else if (bus_tmr >= BUS_TIMEOUT - 16'd1) begin
            o_ribm_req <= 1'b0;
            txq <= 32'h45;
            tx_num <= 3'd1;
            state <= TX_LOAD;
          end else begin
            bus_tmr <= bus_tmr + 16'd1;
          end
        end
        BUS_RSP: begin
          if (i_ribm_rsp) begin
            o_ribm_rdy <= 1'b0;
            txq <= o_ribm_wrcs ? 32'h4B : i_ribm_rdata;
            tx_num <= o_ribm_wrcs ? 3'd1 : 3'd4;
            state <= TX_LOAD;
          end else if (bus_tmr >= BUS_TIMEOUT - 16'd1) begin
            o_ribm_rdy <= 1'b0;
            txq <= 32'h45;
            tx_num <= 3'd1;
            state <= TX_LOAD;
          end else begin
            bus_tmr <= bus_tmr + 16'd1;
          end
        end
        TX_LOAD: begin
          if (tx_rdy) begin
            tx_en <= 1'b1;
            tx_byte <= txq[7:0];
            txq <= {8'h00, txq[31:8]};
            tx_num <= tx_num - 3'd1;
            cnt <= '0;
            state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          tx_en <= 1'b0;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd1) begin
            cnt <= '0;
            state <= tx_num != 3'd0 ? TX_LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rib_bridge.sv
// tb_uart_rib_bridge: directed frames with a queue-based reply model and a cycle-level bus checker
module tb_uart_rib_bridge;
  localparam int D = 8;
  localparam int BT = 300;
  localparam int BUS_T = 40;
  logic clk = 1'b0, rstn = 1'b0, rx = 1'b1;
  logic tx, wrcs, req, gnt, rsp, rdy, busy;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] mask;
  int n_cmp = 0, n_bad = 0;
  int mode = 0, wcnt = 0, req_cyc = 0, rdy_cyc = 0, n_hs = 0;
  logic exp_valid = 1'b0, exp_wrcs = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, last_addr = '0, last_wdata = '0, rx_hist = '0;
  logic last_wrcs = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] frm[$];

  always #5 clk = ~clk;

  uart_rib_bridge #(.BYTE_TIMEOUT(24'd300), .BUS_TIMEOUT(16'd40), .CLK_DIV(16'd8)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_rx(rx), .o_tx(tx),
    .o_ribm_addr(addr), .o_ribm_wrcs(wrcs), .o_ribm_mask(mask), .o_ribm_wdata(wdata),
    .i_ribm_rdata(rdata), .o_ribm_req(req), .i_ribm_gnt(gnt), .i_ribm_rsp(rsp),
    .o_ribm_rdy(rdy), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // responder: mode 0 = gnt after 2 req cycles then rsp on rdy, 1 = gnt+rsp at once, 2 = hang, 3 = gnt only
  always @(negedge clk) begin
    gnt = 1'b0;
    rsp = 1'b0;
    if (rstn) begin
      if (req) begin
        if (mode == 0) begin
          wcnt++;
          if (wcnt == 2) begin gnt = 1'b1; wcnt = 0; end
        end else if (mode == 1) begin
          gnt = 1'b1; rsp = 1'b1;
        end else if (mode == 3) begin
          gnt = 1'b1;
        end
      end
      if (gnt) begin
        n_hs++;
        last_addr = addr; last_wdata = wdata; last_wrcs = wrcs;
      end
      if (mode == 0 && rdy) rsp = 1'b1;
    end
  end

  // compare process: every cycle req is high the request fields must match the model
  always @(negedge clk) begin
    if (rstn) begin
      if (req) begin
        req_cyc++;
        if (!exp_valid) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_req: got addr %h expected no request", addr);
        end else begin
          chk("req_addr", addr, exp_addr);
          chk("req_wrcs", {31'd0, wrcs}, {31'd0, exp_wrcs});
          chk("req_mask", {28'd0, mask}, 32'hF);
          if (exp_wrcs) chk("req_wdata", wdata, exp_wdata);
        end
      end
      if (rdy) rdy_cyc++;
    end
  end

  // serial decoder on the TX line, checked against the reply queue
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rstn && tx === 1'b0) begin
        repeat (D / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          b[i] = tx;
        end
        repeat (D) @(negedge clk);
        chk("tx_stop", {31'd0, tx}, 32'd1);
        rx_hist = {b, rx_hist[31:8]};
        if (exp_tx.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_tx: got %h expected no byte", b);
        end else begin
          chk("tx_byte", {24'd0, b}, {24'd0, exp_tx.pop_front()});
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (D) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (D) @(negedge clk);
    end
    rx = stop_ok;
    repeat (D) @(negedge clk);
    rx = 1'b1;
    repeat (D) @(negedge clk);
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i], 1'b1);
  endtask

  // model: derive the expected request and reply from the frame bytes and responder mode
  task automatic model_cmd();
    exp_valid = 1'b1;
    exp_wrcs = frm[0] == 8'h57;
    exp_addr = {frm[4], frm[3], frm[2], frm[1]};
    if (exp_wrcs) exp_wdata = {frm[8], frm[7], frm[6], frm[5]};
    if (mode == 2) exp_tx.push_back(8'h45);
    else if (mode != 3) begin
      if (exp_wrcs) exp_tx.push_back(8'h4B);
      else for (int i = 0; i < 4; i++) exp_tx.push_back(8'((rdata >> (8 * i)) & 32'hFF));
    end
  endtask

  task automatic finish_cmd(input int e_req, input int e_rdy, input int e_hs);
    int t;
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    chk("busy_timeout", {31'd0, busy}, 32'd0);
    repeat (12 * D) @(negedge clk);
    chk("tx_drained", exp_tx.size(), 32'd0);
    chk("req_cycles", req_cyc, e_req);
    chk("rdy_cycles", rdy_cyc, e_rdy);
    chk("handshakes", n_hs, e_hs);
    exp_valid = 1'b0;
    req_cyc = 0; rdy_cyc = 0; n_hs = 0; wcnt = 0;
  endtask

  initial begin
    int t;
    gnt = 1'b0; rsp = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, 32'd0);
    chk("rst_wrcs", {31'd0, wrcs}, 32'd0);
    chk("rst_mask", {28'd0, mask}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    mode = 0;
    frm = '{8'h57, 8'h00, 8'h10, 8'h00, 8'h20, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model_cmd(); send_frm(); finish_cmd(2, 1, 1);
    chk("wr_addr", last_addr, 32'h2000_1000);
    chk("wr_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("wr_wrcs", {31'd0, last_wrcs}, 32'd1);
    chk("wr_reply", {24'd0, rx_hist[31:24]}, 32'h4B);

    rdata = 32'h1234_5678;
    frm = '{8'h52, 8'h08, 8'h00, 8'h00, 8'h20};
    model_cmd(); send_frm(); finish_cmd(2, 1, 1);
    chk("rd_addr", last_addr, 32'h2000_0008);
    chk("rd_wrcs", {31'd0, last_wrcs}, 32'd0);
    chk("rd_reply", rx_hist, 32'h1234_5678);

    send_byte(8'h33, 1'b1);
    send_byte(8'h52, 1'b1);
    send_byte(8'h04, 1'b1);
    repeat (BT - 30) @(negedge clk);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    repeat (60) @(negedge clk);
    chk("to_busy_after", {31'd0, busy}, 32'd0);
    rdata = 32'hA5A5_0F0F;
    frm = '{8'h52, 8'h10, 8'h00, 8'h00, 8'h00};
    model_cmd(); send_frm(); finish_cmd(2, 1, 1);
    chk("to_rd_addr", last_addr, 32'h0000_0010);
    chk("to_rd_reply", rx_hist, 32'hA5A5_0F0F);

    exp_tx.push_back(8'h45);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b0);
    finish_cmd(0, 0, 0);

    mode = 2;
    frm = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h40};
    model_cmd(); send_frm(); finish_cmd(BUS_T, 0, 0);
    chk("hang_reply", {24'd0, rx_hist[31:24]}, 32'h45);

    mode = 1;
    rdata = 32'hCAFE_F00D;
    frm = '{8'h52, 8'h0C, 8'h00, 8'h00, 8'h20};
    model_cmd(); send_frm(); finish_cmd(1, 0, 1);
    chk("zw_rd_reply", rx_hist, 32'hCAFE_F00D);
    frm = '{8'h57, 8'h04, 8'h00, 8'h00, 8'h30, 8'h11, 8'h22, 8'h33, 8'h44};
    model_cmd(); send_frm(); finish_cmd(1, 0, 1);
    chk("zw_wr_wdata", last_wdata, 32'h4433_2211);
    chk("zw_wr_addr", last_addr, 32'h3000_0004);

    mode = 3;
    frm = '{8'h52, 8'h20, 8'h00, 8'h00, 8'h20};
    model_cmd(); send_frm();
    t = 0;
    while (!rdy && t < 200) begin @(negedge clk); t++; end
    chk("rsp_state_rdy", {31'd0, rdy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_req", {31'd0, req}, 32'd0);
    chk("ar_rdy", {31'd0, rdy}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_addr", addr, 32'd0);
    chk("ar_mask", {28'd0, mask}, 32'd0);
    chk("ar_tx", {31'd0, tx}, 32'd1);
    exp_valid = 1'b0;
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (12 * D) @(negedge clk);
    chk("ar_no_tx", exp_tx.size(), 32'd0);
    chk("ar_handshakes", n_hs, 32'd1);
    chk("ar_tx_idle", {31'd0, tx}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
